uart_rx_word: RTL and testbench



---
 rtl/uart_rx_word_if.sv | 32 +++
 rtl/uart_rx_word.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_word.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: serial input, enable and received-word status of the
// 8N1 UART receiver. The master modport is the side that owns the line and
// consumes words. The slave modport is the receiver itself.
interface uart_rx_word_if;
  logic       rx;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       word_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx,
    output rx_en,
    input  rx_data,
    input  word_done,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  rx_en,
    output rx_data,
    output word_done,
    output frame_err,
    output parity_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver with a one-cycle word-complete strobe.
// Bits are sampled at mid-bit using a down-counter that reloads every
// DIV = CLK_FREQ/BAUD_RATE clocks.
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data bits and the stop bit. Without it, parity_err is tied 0.
module uart_rx_word #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 3125000
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_word_if.slave  bus
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          wait_high_q, wait_high_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          word_done_q, word_done_d;
  logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          parity_err_q, parity_err_d;
`endif

  // Next-state logic: receive FSM, bit timing, and the word result registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_meta_d   = bus.rx;
    rx_s_d      = rx_meta_q;
    wait_high_d = wait_high_q;
    rx_data_d   = rx_data_q;
    word_done_d = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (wait_high_q) begin
          if (rx_s_q) begin
            wait_high_d = 1'b0;
          end
        end else if (!rx_s_q && bus.rx_en) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (!bus.rx_en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = 3'd0;
        end
      end

      DATA: begin
        if (!bus.rx_en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!bus.rx_en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bit_d = rx_s_q;
          cnt_d     = FULL_LOAD;
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (!bus.rx_en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rx_data_d   = shift_q;
          frame_err_d = ~rx_s_q;
          word_done_d = 1'b1;
          wait_high_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
          parity_err_d = (^shift_q) ^ par_bit_q;
`endif
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; the rx synchronizer resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      wait_high_q  <= 1'b0;
      rx_data_q    <= 8'h00;
      word_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      wait_high_q  <= wait_high_d;
      rx_data_q    <= rx_data_d;
      word_done_q  <= word_done_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.word_done = word_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed and randomized frames for uart_rx_word.
// Expected words come from the frame contents and the 8N1 rules.
// Define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx_word;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 3125000;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LATENCY = 2 + 1 + DIV / 2 + (FRAME_BITS - 1) * DIV;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cycle_cnt = 0;
  int    compared = 0;
  int    mismatched = 0;
  word_t exp_q[$];
  word_t got_q[$];

  uart_rx_word_if ifc();

  uart_rx_word #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // 100 MHz bench clock; the design only sees cycles.
  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp start edges and strobes.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Capture every clock where the strobe is high, away from the rising edge.
  always @(negedge clk) begin
    if (ifc.word_done === 1'b1)
      got_q.push_back('{ifc.rx_data, ifc.frame_err, ifc.parity_err, cycle_cnt});
  end

  // Hard stop if the run wanders off.
  initial begin
    #(10 * 80000);
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] run exceeded its cycle budget");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Drive one frame; a word is expected only when expect_word is set.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_bit, input bit expect_word,
                               input int abort_bit);
    logic [10:0] frame;
    logic        exp_pe;
`ifdef UART_RX_PARITY_EN
    frame  = {stop_bit, par_bit, data, 1'b0};
    exp_pe = (^data) ^ par_bit;
`else
    frame  = {par_bit, stop_bit, data, 1'b0};
    exp_pe = 1'b0;
`endif
    if (expect_word)
      exp_q.push_back('{data, ~stop_bit, exp_pe, cycle_cnt + LATENCY});
    for (int i = 0; i < FRAME_BITS; i++) begin
      ifc.rx = frame[i];
      if (i == abort_bit) begin
        ifc.rx_en = 1'b0;
        wait_cycles(1);
        checkOutput("abort_busy", {31'd0, ifc.busy}, 32'd0);
        wait_cycles(DIV - 1);
      end else begin
        wait_cycles(DIV);
      end
    end
    ifc.rx = 1'b1;
  endtask

  task automatic check_words(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      word_t g;
      word_t e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_data"}, {24'd0, g.data}, {24'd0, e.data});
      checkOutput({tag, "_frame_err"}, {31'd0, g.fe}, {31'd0, e.fe});
      checkOutput({tag, "_parity_err"}, {31'd0, g.pe}, {31'd0, e.pe});
      checkOutput({tag, "_latency"}, g.cyc, e.cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    logic       pb;
    int         gap;

    ifc.rx    = 1'b1;
    ifc.rx_en = 1'b1;

    // Reset and a long idle line.
    wait_cycles(5);
    checkOutput("rst_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("rst_word_done", {31'd0, ifc.word_done}, 32'd0);
    checkOutput("rst_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, ifc.frame_err}, 32'd0);
    checkOutput("rst_parity_err", {31'd0, ifc.parity_err}, 32'd0);
    rst = 1'b0;
    wait_cycles(200);
    checkOutput("idle_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("idle_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    check_words("idle");

    // Single clean byte with latency check.
    applyStimulus(8'h55, 1'b1, even_par(8'h55), 1'b1, -1);
    wait_cycles(DIV);
    check_words("byte55");

    // Back-to-back frames with no idle gap.
    applyStimulus(8'hA5, 1'b1, even_par(8'hA5), 1'b1, -1);
    applyStimulus(8'h3C, 1'b1, even_par(8'h3C), 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, even_par(8'hFF), 1'b1, -1);
    wait_cycles(DIV);
    check_words("b2b");

    // Framing error, held status, then cleared by a clean word.
    applyStimulus(8'h81, 1'b0, even_par(8'h81), 1'b1, -1);
    wait_cycles(2 * DIV);
    checkOutput("ferr_hold", {31'd0, ifc.frame_err}, 32'd1);
    checkOutput("ferr_data_hold", {24'd0, ifc.rx_data}, 32'h81);
    applyStimulus(8'h12, 1'b1, even_par(8'h12), 1'b1, -1);
    wait_cycles(DIV);
    check_words("ferr");
    checkOutput("ferr_clear", {31'd0, ifc.frame_err}, 32'd0);

    // Short low glitch on an idle line.
    ifc.rx = 1'b0;
    wait_cycles(4);
    ifc.rx = 1'b1;
    checkOutput("glitch_busy_hi", {31'd0, ifc.busy}, 32'd1);
    wait_cycles(DIV);
    checkOutput("glitch_busy_lo", {31'd0, ifc.busy}, 32'd0);
    check_words("glitch");

    // Receiver disabled in the middle of the third byte.
    applyStimulus(8'h11, 1'b1, even_par(8'h11), 1'b1, -1);
    applyStimulus(8'h22, 1'b1, even_par(8'h22), 1'b1, -1);
    applyStimulus(8'h33, 1'b1, even_par(8'h33), 1'b0, 4);
    wait_cycles(DIV);
    ifc.rx_en = 1'b1;
    wait_cycles(DIV);
    check_words("rx_en");
    checkOutput("abort_data_hold", {24'd0, ifc.rx_data}, 32'h22);
    checkOutput("abort_ferr_hold", {31'd0, ifc.frame_err}, 32'd0);

    // Break: one zero word with framing error, no restart while low.
    exp_q.push_back('{8'h00, 1'b1, 1'b0, cycle_cnt + LATENCY});
    ifc.rx = 1'b0;
    wait_cycles(30 * DIV);
    checkOutput("break_busy", {31'd0, ifc.busy}, 32'd0);
    ifc.rx = 1'b1;
    wait_cycles(2 * DIV);
    check_words("break");

`ifdef UART_RX_PARITY_EN
    // Parity bit correct, then wrong.
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, -1);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, -1);
    wait_cycles(DIV);
    check_words("parity");
`endif

    // Randomized frames, occasional bad stop bit and random parity bit.
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      pb = 1'($urandom_range(0, 1));
      applyStimulus(b, sb, pb, 1'b1, -1);
      gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
      wait_cycles(gap * DIV);
    end
    wait_cycles(DIV);
    check_words("random");

    // Reset in the middle of a frame.
    ifc.rx = 1'b0;
    wait_cycles(5 * DIV);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("midrst_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    checkOutput("midrst_frame_err", {31'd0, ifc.frame_err}, 32'd0);
    checkOutput("midrst_parity_err", {31'd0, ifc.parity_err}, 32'd0);
    ifc.rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(4 * DIV);
    checkOutput("post_rst_busy", {31'd0, ifc.busy}, 32'd0);
    check_words("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
